// File: rtl/npu_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : npu_sequencer
// Brief   : NPU inference controller (config phase, compute phase, argmax of scores).
//           Optional RUN watchdog: define NPU_SEQ_TIMEOUT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
module npu_sequencer #(
  parameter int N_CLASSES      = 10,
  parameter int CFG_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] control_reg,
  input  logic [7:0]  d_out,
  input  logic        d_out_valid,
  output logic        en_config,
  output logic        en_fsm,
  output logic        busy,
  output logic [31:0] ready,
  output logic [31:0] answer
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONFIG = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [7:0] CFG_LAST   = 8'(CFG_CYCLES - 1);
  localparam logic [4:0] SCORE_LAST = 5'(N_CLASSES - 1);

  logic [1:0]  state_q, state_d;
  logic        start_q;
  logic [7:0]  cfg_cnt_q, cfg_cnt_d;
  logic [4:0]  score_cnt_q, score_cnt_d;
  logic [7:0]  max_q, max_d;
  logic [3:0]  idx_q, idx_d;
  logic        en_config_q, en_config_d;
  logic        en_fsm_q, en_fsm_d;
  logic        busy_q, busy_d;
  logic [1:0]  ready_q, ready_d;
  logic [31:0] answer_q, answer_d;

  logic        start_pulse;
  logic        abort;
  logic        score_wins;
  logic        last_valid;
  logic [7:0]  new_max;
  logic [3:0]  new_idx;
  logic        unused_ctrl;

  assign unused_ctrl = ^control_reg[31:2];
  assign start_pulse = control_reg[0] & ~start_q;
  assign abort       = control_reg[1];

  // First score of a run always seeds the max; later ones must be strictly greater.
  assign score_wins = (score_cnt_q == 5'd0) || ($signed(d_out) > $signed(max_q));
  assign new_max    = score_wins ? d_out : max_q;
  assign new_idx    = score_wins ? score_cnt_q[3:0] : idx_q;
  assign last_valid = d_out_valid && (score_cnt_q == SCORE_LAST);

`ifdef NPU_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q, tmo_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= 16'd0;
    else       tmo_q <= tmo_d;
  end
`else
  logic [15:0] unused_tmo;
  assign unused_tmo = 16'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d     = state_q;
    cfg_cnt_d   = cfg_cnt_q;
    score_cnt_d = score_cnt_q;
    max_d       = max_q;
    idx_d       = idx_q;
    en_config_d = en_config_q;
    en_fsm_d    = en_fsm_q;
    ready_d     = ready_q;
    answer_d    = answer_q;
`ifdef NPU_SEQ_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    if (abort && (state_q == S_CONFIG || state_q == S_RUN)) begin
      state_d     = S_IDLE;
      en_config_d = 1'b0;
      en_fsm_d    = 1'b0;
      ready_d     = 2'b00;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_pulse) begin
            state_d     = S_CONFIG;
            en_config_d = 1'b1;
            ready_d     = 2'b00;
            cfg_cnt_d   = 8'd0;
          end
        end
        S_CONFIG: begin
          if (cfg_cnt_q == CFG_LAST) begin
            state_d     = S_RUN;
            en_config_d = 1'b0;
            en_fsm_d    = 1'b1;
            score_cnt_d = 5'd0;
            max_d       = 8'd0;
            idx_d       = 4'd0;
`ifdef NPU_SEQ_TIMEOUT_EN
            tmo_d       = 16'd0;
`endif
          end else begin
            cfg_cnt_d = cfg_cnt_q + 8'd1;
          end
        end
        S_RUN: begin
          if (d_out_valid) begin
            max_d       = new_max;
            idx_d       = new_idx;
            score_cnt_d = score_cnt_q + 5'd1;
          end
          // Completion is tested first so it beats a same-cycle timeout.
          if (last_valid) begin
            state_d  = S_DONE;
            en_fsm_d = 1'b0;
            ready_d  = 2'b01;
            answer_d = {16'h0000, new_max, 4'h0, new_idx};
          end
`ifdef NPU_SEQ_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_d  = S_DONE;
            en_fsm_d = 1'b0;
            ready_d  = 2'b11;
            answer_d = 32'hFFFF_FFFF;
          end
          tmo_d = tmo_q + 16'd1;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = en_config_d | en_fsm_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      cfg_cnt_q   <= 8'd0;
      score_cnt_q <= 5'd0;
      max_q       <= 8'd0;
      idx_q       <= 4'd0;
      en_config_q <= 1'b0;
      en_fsm_q    <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 2'b00;
      answer_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      start_q     <= control_reg[0];
      cfg_cnt_q   <= cfg_cnt_d;
      score_cnt_q <= score_cnt_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      en_config_q <= en_config_d;
      en_fsm_q    <= en_fsm_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      answer_q    <= answer_d;
    end
  end

  assign en_config = en_config_q;
  assign en_fsm    = en_fsm_q;
  assign busy      = busy_q;
  assign ready     = {30'd0, ready_q};
  assign answer    = answer_q;

endmodule
`default_nettype wire

// File: tb/tb_npu_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_npu_sequencer
// Brief   : scoreboard bench for npu_sequencer with an argmax reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_npu_sequencer;
  localparam int N   = 10;
  localparam int CFG = 16;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] control_reg;
  logic [7:0]  d_out;
  logic        d_out_valid;
  logic        en_config;
  logic        en_fsm;
  logic        busy;
  logic [31:0] ready;
  logic [31:0] answer;

  npu_sequencer #(.N_CLASSES(N), .CFG_CYCLES(CFG), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .control_reg (control_reg),
    .d_out       (d_out),
    .d_out_valid (d_out_valid),
    .en_config   (en_config),
    .en_fsm      (en_fsm),
    .busy        (busy),
    .ready       (ready),
    .answer      (answer)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdy;
    logic [31:0] ans;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               n_checks = 0;
  int               n_fail   = 0;
  logic signed [7:0] sc [N];
  logic [31:0]      model_ans;
  logic             prev_done = 1'b0;
  int               cfg_len   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Argmax with first-occurrence tie break.
  function automatic logic [31:0] ref_ans();
    int best;
    int bi;
    best = int'(sc[0]);
    bi   = 0;
    for (int i = 1; i < N; i++) begin
      if (int'(sc[i]) > best) begin
        best = int'(sc[i]);
        bi   = i;
      end
    end
    return {16'h0000, 8'(best), 4'h0, 4'(bi)};
  endfunction

  // Monitor: invariants every cycle, scoreboard pop on each new done.
  always @(negedge clk) begin
    if (reset) begin
      prev_done = 1'b0;
      cfg_len   = 0;
    end else begin
      check("enables_exclusive", {31'd0, en_config & en_fsm}, 32'd0);
      check("busy_tracks_enables", {31'd0, busy}, {31'd0, en_config | en_fsm});
      if (en_config) cfg_len++;
      else begin
        if (cfg_len != 0 && en_fsm) check("config_length", cfg_len, CFG);
        cfg_len = 0;
      end
      if (ready[0] && !prev_done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: ready=0x%08h answer=0x%08h, expected no result", ready, answer);
        end else begin
          mon_e = exp_q.pop_front();
          check("result_ready", ready, mon_e.rdy);
          check("result_answer", answer, mon_e.ans);
        end
      end
      prev_done = ready[0];
    end
  end

  task automatic start_edge();
    @(negedge clk);
    control_reg[0] = 1'b0;
    d_out_valid    = 1'b1;
    d_out          = 8'h7F;
    @(negedge clk);
    control_reg[0] = 1'b1;
    d_out_valid    = 1'b0;
    @(negedge clk);
    check("start_enters_config", {30'd0, busy, en_config}, 32'h3);
    check("start_clears_ready", ready, 32'd0);
    check("answer_kept_on_start", answer, model_ans);
  endtask

  task automatic wait_run();
    int g;
    g = 0;
    while (!en_fsm && g < 300) begin
      d_out_valid = 1'($urandom_range(0, 1));
      d_out       = 8'h7F;
      @(negedge clk);
      g++;
    end
    d_out_valid = 1'b0;
    if (!en_fsm) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_run: en_fsm=0 after %0d cycles, expected 1", g);
    end
  endtask

  task automatic send_scores(input int count);
    int gap;
    for (int i = 0; i < count; i++) begin
      gap = $urandom_range(0, 2);
      d_out_valid = 1'b0;
      repeat (gap) @(negedge clk);
      d_out       = sc[i];
      d_out_valid = 1'b1;
      @(negedge clk);
    end
    d_out_valid = 1'b0;
  endtask

  task automatic do_run(input logic [31:0] rdy, input logic [31:0] ans);
    start_edge();
    wait_run();
    exp_q.push_back(exp_t'{rdy, ans});
    model_ans = ans;
    send_scores(N);
    check("done_enables_low", {29'd0, en_config, en_fsm, busy}, 32'd0);
    @(negedge clk);
    check("result_delivered", exp_q.size(), 32'd0);
  endtask

`ifdef NPU_SEQ_TIMEOUT_EN
  task automatic timeout_tests();
    int cyc;
    start_edge();
    wait_run();
    exp_q.push_back(exp_t'{32'h3, 32'hFFFF_FFFF});
    model_ans = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      d_out = 8'(i); d_out_valid = 1'b1; @(negedge clk);
    end
    d_out_valid = 1'b0;
    cyc = 3;
    while (en_fsm && cyc < 300) begin @(negedge clk); cyc++; end
    check("timeout_run_length", cyc, TMO);
    @(negedge clk);
    check("timeout_result_delivered", exp_q.size(), 32'd0);
    // Final valid lands on the same edge as the timeout.
    for (int i = 0; i < N; i++) sc[i] = 8'($urandom_range(0, 255));
    start_edge();
    wait_run();
    exp_q.push_back(exp_t'{32'h1, ref_ans()});
    model_ans = ref_ans();
    for (int i = 0; i < N - 1; i++) begin
      d_out = sc[i]; d_out_valid = 1'b1; @(negedge clk);
    end
    d_out_valid = 1'b0;
    cyc = N - 1;
    while (cyc < TMO - 1) begin @(negedge clk); cyc++; end
    d_out = sc[N-1]; d_out_valid = 1'b1;
    @(negedge clk);
    d_out_valid = 1'b0;
    check("tie_timeout_fsm_low", {31'd0, en_fsm}, 32'd0);
    @(negedge clk);
    check("tie_result_delivered", exp_q.size(), 32'd0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int v;
    reset       = 1'b1;
    control_reg = 32'd0;
    d_out       = 8'd0;
    d_out_valid = 1'b0;
    model_ans   = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_ready", ready, 32'd0);
    check("reset_answer", answer, 32'd0);
    check("reset_enables", {29'd0, en_config, en_fsm, busy}, 32'd0);
    reset = 1'b0;

    sc = '{8'h03, 8'hFB, 8'h07, 8'h0C, 8'h00, 8'h0C, 8'h80, 8'h01, 8'h09, 8'h02};
    do_run(32'h1, 32'h0000_0C03);

    repeat (20) @(negedge clk);
    check("no_retrigger_enables", {29'd0, en_config, en_fsm, busy}, 32'd0);
    check("done_holds_ready", ready, 32'h1);
    check("done_holds_answer", answer, 32'h0000_0C03);

    for (int i = 0; i < N; i++) sc[i] = 8'hFF;
    do_run(32'h1, 32'h0000_FF00);

    for (int i = 0; i < N - 1; i++) sc[i] = 8'($urandom_range(0, 254));
    sc[N-1] = 8'h7F;
    do_run(32'h1, 32'h0000_7F09);

    start_edge();
    wait_run();
    send_scores(4);
    control_reg[1] = 1'b1;
    @(negedge clk);
    control_reg[1] = 1'b0;
    check("abort_enables_low", {29'd0, en_config, en_fsm, busy}, 32'd0);
    check("abort_ready_clear", ready, 32'd0);
    check("abort_answer_kept", answer, model_ans);
    repeat (5) @(negedge clk);
    check("abort_stays_idle", {29'd0, en_config, en_fsm, busy}, 32'd0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        if (r % 2 == 0) sc[i] = 8'($urandom_range(0, 255));
        else begin
          v = $urandom_range(0, 3);
          sc[i] = 8'(v - 2);
        end
      end
      do_run(32'h1, ref_ans());
    end

`ifdef NPU_SEQ_TIMEOUT_EN
    timeout_tests();
`endif

    start_edge();
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_enables", {29'd0, en_config, en_fsm, busy}, 32'd0);
    check("async_reset_ready", ready, 32'd0);
    check("async_reset_answer", answer, 32'd0);
    control_reg = 32'd0;
    model_ans   = 32'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {29'd0, en_config, en_fsm, busy}, 32'd0);

    for (int i = 0; i < N; i++) sc[i] = 8'($urandom_range(0, 255));
    do_run(32'h1, ref_ans());

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/npu_sequencer.md
# npu_sequencer

Single-inference controller for the NPU datapath. It decodes host commands from `control_reg`, runs the NPU through a configuration phase (`EN_CONFIG`) and then a compute phase (`EN_FSM`), and collects the class scores streamed on `D_OUT`. It resolves those scores to an argmax result and publishes it on the host-visible `ready`/`answer` registers. It sits in the memory/NPU top level alongside the memory write and read modules and replaces the static enables there.

## Interface
- `N_CLASSES`, 10: score bytes expected per inference (2–16).
- `CFG_CYCLES`, 16: cycles `en_config` is held high (1–255).
- `TIMEOUT_CYCLES`, 65535: RUN watchdog limit (used only with the macro).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `control_reg` in 32: bit0 `start` (level; rising edge acts), bit1 `abort` (level), others ignored.
- `d_out` in 8: signed class score from the NPU output PISO.
- `d_out_valid` in 1: one-cycle strobe, `d_out` valid this cycle.
- `en_config` out 1: NPU configuration enable.
- `en_fsm` out 1: NPU compute FSM enable.
- `busy` out 1: high in CONFIG or RUN.
- `ready` out 32: bit0 done, bit1 timeout error, others 0.
- `answer` out 32: [3:0] argmax index, [15:8] max score, others 0.

## Operation
- States: IDLE, CONFIG, RUN, DONE. All outputs are registered.
- Reset values: state IDLE, `en_config`=0, `en_fsm`=0, `busy`=0, `ready`=0, `answer`=0, start-edge register=0, counters=0.
- Start edge: `start_pulse` = `control_reg[0]` & ~`start_q`, where `start_q` is `control_reg[0]` registered every cycle.
- IDLE or DONE with `start_pulse`:
  - Go to CONFIG.
  - Clear `ready` and the cycle counter.
  - Keep `answer` unchanged until the new result is written.
- CONFIG:
  - `en_config`=1.
  - After exactly `CFG_CYCLES` cycles, go to RUN with `en_config`=0 and `en_fsm`=1.
  - Reset the score count and the max register.
- RUN:
  - Each `d_out_valid` captures `d_out`.
  - The first score initialises max/index.
  - A later score replaces them only if it is strictly greater (signed 8-bit compare). Ties keep the lowest index.
  - On the `N_CLASSES`-th valid, next state is DONE, with `en_fsm`=0, `ready[0]`=1 and `answer` loaded from the final max/index. The final score itself is included in the compare.
- DONE: hold `ready`/`answer` until the next `start_pulse`.
- `abort` high in CONFIG or RUN: next cycle IDLE, enables and `busy` low, `ready`=0, `answer` unchanged. `abort` has no effect in IDLE or DONE.
- Abort has priority over completion and timeout in the same cycle.
- `start_pulse` in CONFIG or RUN is ignored. The edge register still updates, so holding `start` high does not retrigger.
- `d_out_valid` outside RUN is ignored. Extra valids cannot occur in RUN because the state leaves on the last one.

## Timing
- `start` rising at edge k: `start_q` and the edge are seen at edge k+1 → CONFIG. `en_config` is high for edges k+1 through k+CFG_CYCLES, and `en_fsm` rises at k+CFG_CYCLES+1.
- Last valid sampled at edge m: `ready[0]`, `answer` and `en_fsm`=0 all take effect at edge m (visible after m).
- `en_config` and `en_fsm` are never high together.
- `busy` is high exactly while either enable is high.
- Asynchronous reset mid-operation forces the reset values immediately. The first `start` after reset release requires a fresh 0→1 edge.

## Configuration
- `NPU_SEQ_TIMEOUT_EN` defined:
  - A 16-bit counter runs in RUN and clears on RUN entry.
  - If it reaches `TIMEOUT_CYCLES` before `N_CLASSES` valids arrive, next state is DONE with `ready`=0x3 (done + error), `answer`=0xFFFF_FFFF and `en_fsm`=0.
  - A completion valid in the same cycle wins over the timeout.
- Not defined: no counter or timeout logic, `ready[1]` is tied to 0, and RUN waits indefinitely.

## Test plan
- Nominal run: N_CLASSES=10, scores 3,−5,7,12,0,12,−128,1,9,2 → `ready`=0x1, `answer`=0x0000_0C03, `en_config` high exactly 16 cycles.
- All scores equal −1 → index 0, `answer`=0x0000_FF00. Scores 127 at index 9 only → `answer`=0x0000_7F09.
- Abort after 4 valids in RUN → IDLE next cycle, `ready`=0, prior `answer` kept. A new start edge yields a correct fresh result.
- `start` held high through DONE → no retrigger. Drop then raise `start` in DONE → `ready` clears, CONFIG begins. Valids in IDLE/CONFIG → no effect on the result.
- With `NPU_SEQ_TIMEOUT_EN`, TIMEOUT_CYCLES=100, only 3 valids → after 100 RUN cycles `ready`=0x3, `answer`=0xFFFF_FFFF. A valid and the timeout in the same cycle for the final score → normal result.
- Assert `reset` mid-CONFIG → all outputs are 0 asynchronously and the state is IDLE.
